// File: rtl/cbus_arbiter.sv
// Round-robin arbiter that shares the memory-side cache bus between NumPorts requesters.
// A grant is held for a whole burst and released after the beat flagged last.

typedef struct packed {
  logic        valid;
  logic        is_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  strobe;
  logic [31:0] data;
  logic [7:0]  len;
} cbus_req_t;

typedef struct packed {
  logic        ready;
  logic        last;
  logic [31:0] data;
} cbus_resp_t;

module cbus_arbiter #(
  parameter int unsigned NumPorts = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  cbus_req_t  [NumPorts-1:0] ireqs_i,
  output cbus_resp_t [NumPorts-1:0] iresps_o,
  output cbus_req_t                 oreq_o,
  input  cbus_resp_t                oresp_i
);

  localparam int unsigned SelW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [SelW-1:0] LastPort = SelW'(NumPorts - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [SelW-1:0] scan_idx;
  logic [SelW-1:0] pick;
  logic            pick_vld;
  logic            burst_done;

  // First valid port found scanning ptr, ptr+1, ... modulo NumPorts.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      scan_idx = SelW'((32'(ptr_q) + i) % NumPorts);
      if (!pick_vld && ireqs_i[scan_idx].valid) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign burst_done = oresp_i.ready && oresp_i.last;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    oreq_o   = '0;
    iresps_o = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          sel_d   = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Pass-through keeps per-beat write data/strobe visible downstream.
        oreq_o          = ireqs_i[sel_q];
        iresps_o[sel_q] = oresp_i;
        if (burst_done) begin
          state_d = StIdle;
          ptr_d   = (sel_q == LastPort) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: a 2-port and a 3-port instance driven by directed scenarios and
// random traffic, compared each cycle against a burst-ownership model.
module tb_cbus_arbiter;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  req_t       rq [2][3];
  rsp_t       rs [2];
  req_t [1:0] a_req;
  req_t [2:0] b_req;
  rsp_t [1:0] a_rsp;
  rsp_t [2:0] b_rsp;
  req_t       a_oreq, b_oreq;

  assign a_req = {rq[0][1], rq[0][0]};
  assign b_req = {rq[1][2], rq[1][1], rq[1][0]};

  cbus_arbiter #(.NumPorts(2)) u_dut2 (
    .clk     (clk),
    .resetn  (resetn),
    .ireqs_i (a_req),
    .iresps_o(a_rsp),
    .oreq_o  (a_oreq),
    .oresp_i (rs[0])
  );

  cbus_arbiter #(.NumPorts(3)) u_dut3 (
    .clk     (clk),
    .resetn  (resetn),
    .ireqs_i (b_req),
    .iresps_o(b_rsp),
    .oreq_o  (b_oreq),
    .oresp_i (rs[1])
  );

  // Model: which port owns the bus (-1 = none), who has priority next, beats seen so far.
  int own_m [2];
  int prio_m [2];
  int beat_m [2];
  bit done_m [2][3];
  int nvec = 0;
  int nerr = 0;

  function automatic int np(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic req_t got_oreq(input int k);
    return (k == 0) ? a_oreq : b_oreq;
  endfunction

  function automatic rsp_t got_rsp(input int k, input int p);
    if (k == 0) return a_rsp[p];
    return b_rsp[p];
  endfunction

  function automatic req_t exp_oreq(input int k);
    if (own_m[k] < 0) return '0;
    return rq[k][own_m[k]];
  endfunction

  function automatic rsp_t exp_rsp(input int k, input int p);
    if (own_m[k] != p) return '0;
    return rs[k];
  endfunction

  task automatic new_req(input int k, input int p, input int len, input bit wr);
    req_t r;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'($urandom_range(0, 3));
    r.addr     = {4'(p), 28'($urandom)};
    r.strobe   = 4'($urandom);
    r.data     = $urandom;
    r.len      = 8'(len);
    rq[k][p]   = r;
  endtask

  task automatic jitter(input int k);
    for (int p = 0; p < np(k); p++) begin
      if (rq[k][p].valid) begin
        rq[k][p].data   = $urandom;
        rq[k][p].strobe = 4'($urandom);
      end
    end
  endtask

  task automatic release_done(input int k);
    for (int p = 0; p < np(k); p++) if (done_m[k][p]) rq[k][p].valid = 1'b0;
  endtask

  // Bridge: flags last on the beat matching the owner's len; last is noise when idle.
  task automatic drive_bridge(input int k, input bit rdy);
    rs[k].ready = rdy;
    rs[k].data  = $urandom;
    if (own_m[k] >= 0) rs[k].last = (beat_m[k] == int'(rq[k][own_m[k]].len));
    else rs[k].last = 1'($urandom);
  endtask

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 3; p++) done_m[k][p] = 1'b0;
      if (!resetn) begin
        own_m[k]  = -1;
        prio_m[k] = 0;
        beat_m[k] = 0;
      end else if (own_m[k] >= 0) begin
        if (rs[k].ready && rs[k].last) begin
          done_m[k][own_m[k]] = 1'b1;
          prio_m[k] = (own_m[k] + 1) % np(k);
          own_m[k]  = -1;
          beat_m[k] = 0;
        end else if (rs[k].ready) begin
          beat_m[k]++;
        end
      end else begin
        for (int j = 0; j < np(k); j++) begin
          if (own_m[k] < 0 && rq[k][(prio_m[k] + j) % np(k)].valid)
            own_m[k] = (prio_m[k] + j) % np(k);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    new_req(0, 0, 0, 1'b0);
    new_req(0, 1, 0, 1'b0);
    drive_bridge(0, 1'b1);
    drive_bridge(1, 1'b1);
    advance();
    advance();
    #2;
    nvec++;
    if (a_oreq !== '0) begin
      nerr++;
      $display("FAIL reset oreq2 got=%h want=0", a_oreq);
    end
    nvec++;
    if (a_rsp !== '0) begin
      nerr++;
      $display("FAIL reset iresps2 got=%h want=0", a_rsp);
    end
    nvec++;
    if (b_oreq !== '0) begin
      nerr++;
      $display("FAIL reset oreq3 got=%h want=0", b_oreq);
    end
    nvec++;
    if (b_rsp !== '0) begin
      nerr++;
      $display("FAIL reset iresps3 got=%h want=0", b_rsp);
    end
    resetn = 1'b1;
    for (int t = 0; t < 8; t++) begin
      release_done(0);
      drive_bridge(0, 1'b1);
      #2;
      if (t == 1) begin
        nvec++;
        if (a_oreq.valid !== 1'b1 || a_oreq.addr[31:28] !== 4'd0) begin
          nerr++;
          $display("FAIL reset first_grant t=%0d got=%h want port0", t, a_oreq);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL reset oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k), exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL reset iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_single_requester();
    for (int t = 0; t < 7; t++) begin
      if (t == 0) new_req(0, 1, 3, 1'b0);
      if (t == 5) rq[0][1].valid = 1'b0;
      rs[0].ready = (t >= 1 && t <= 4);
      rs[0].last  = (t == 4);
      rs[0].data  = $urandom;
      #2;
      if (t >= 1 && t <= 4) begin
        nvec++;
        if (a_oreq !== rq[0][1] || a_rsp[1] !== rs[0] || a_rsp[0] !== '0) begin
          nerr++;
          $display("FAIL single beat t=%0d oreq=%h resp1=%h resp0=%h", t, a_oreq, a_rsp[1],
                   a_rsp[0]);
        end
      end
      if (t == 5) begin
        nvec++;
        if (a_oreq.valid !== 1'b0) begin
          nerr++;
          $display("FAIL single idle t=%0d got valid=%b want 0", t, a_oreq.valid);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL single oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k), exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL single iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    int served0 = 0;
    for (int t = 0; t < 11; t++) begin
      if (t == 0) begin
        new_req(0, 0, 1, 1'b0);
        new_req(0, 1, 1, 1'b0);
      end
      if (done_m[0][0]) begin
        served0++;
        if (served0 == 1) new_req(0, 0, 1, 1'b1);
        else rq[0][0].valid = 1'b0;
      end
      if (done_m[0][1]) rq[0][1].valid = 1'b0;
      drive_bridge(0, 1'b1);
      #2;
      if (t == 1 || t == 4 || t == 7) begin
        nvec++;
        if (a_oreq.valid !== 1'b1 || a_oreq.addr[31:28] !== ((t == 4) ? 4'd1 : 4'd0)) begin
          nerr++;
          $display("FAIL contention grant t=%0d got=%h", t, a_oreq);
        end
      end
      if (t == 3 || t == 6) begin
        nvec++;
        if (a_oreq.valid !== 1'b0) begin
          nerr++;
          $display("FAIL contention bubble t=%0d got valid=%b want 0", t, a_oreq.valid);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL contention oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k),
                   exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL contention iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int t = 0; t < 12; t++) begin
      if (t == 0) begin
        new_req(0, 1, 1, 1'b1);
        new_req(0, 0, 0, 1'b0);
      end
      release_done(0);
      jitter(0);
      drive_bridge(0, (t == 3 || t == 7 || t >= 9));
      #2;
      if (t >= 1 && t <= 7) begin
        nvec++;
        if (a_oreq.valid !== 1'b1 || a_oreq.data !== rq[0][1].data ||
            a_oreq.strobe !== rq[0][1].strobe || a_rsp[0].ready !== 1'b0 ||
            a_rsp[1].ready !== 1'(t == 3 || t == 7)) begin
          nerr++;
          $display("FAIL stall hold t=%0d oreq=%h resp0=%h resp1=%h", t, a_oreq, a_rsp[0],
                   a_rsp[1]);
        end
      end
      if (t == 9) begin
        nvec++;
        if (a_oreq.addr[31:28] !== 4'd0 || a_rsp[0].ready !== 1'b1) begin
          nerr++;
          $display("FAIL stall next_grant t=%0d oreq=%h resp0=%h", t, a_oreq, a_rsp[0]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL stall oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k), exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL stall iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_single_beat();
    for (int t = 0; t < 9; t++) begin
      if (t == 0) new_req(0, 0, 0, 1'b0);
      release_done(0);
      if (t == 3) begin
        new_req(0, 0, 0, 1'b0);
        new_req(0, 1, 0, 1'b0);
      end
      drive_bridge(0, 1'b1);
      #2;
      if (t == 1) begin
        nvec++;
        if (a_oreq.valid !== 1'b1 || a_rsp[0].ready !== 1'b1 || a_rsp[0].last !== 1'b1) begin
          nerr++;
          $display("FAIL single_beat busy t=%0d oreq=%h resp0=%h", t, a_oreq, a_rsp[0]);
        end
      end
      if (t == 2) begin
        nvec++;
        if (a_oreq.valid !== 1'b0) begin
          nerr++;
          $display("FAIL single_beat idle t=%0d got valid=%b want 0", t, a_oreq.valid);
        end
      end
      if (t == 4) begin
        nvec++;
        if (a_oreq.valid !== 1'b1 || a_oreq.addr[31:28] !== 4'd1) begin
          nerr++;
          $display("FAIL single_beat ptr t=%0d got=%h want port1", t, a_oreq);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL single_beat oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k),
                   exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL single_beat iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int t = 0; t < 16; t++) begin
      if (t == 0) begin
        new_req(0, 0, 3, 1'b0);
        new_req(0, 1, 3, 1'b1);
      end
      release_done(0);
      jitter(0);
      resetn = (t != 2);
      drive_bridge(0, 1'b1);
      #2;
      if (t == 3) begin
        nvec++;
        if (a_oreq !== '0 || a_rsp !== '0) begin
          nerr++;
          $display("FAIL reset_mid cleared t=%0d oreq=%h iresps=%h want 0", t, a_oreq, a_rsp);
        end
      end
      if (t == 4) begin
        nvec++;
        if (a_oreq.valid !== 1'b1 || a_oreq.addr[31:28] !== 4'd0) begin
          nerr++;
          $display("FAIL reset_mid regrant t=%0d got=%h want port0", t, a_oreq);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL reset_mid oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k),
                   exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL reset_mid iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
    resetn = 1'b1;
  endtask

  task automatic test_three_ports();
    for (int t = 0; t < 16; t++) begin
      if (t == 0) for (int p = 0; p < 3; p++) new_req(1, p, 0, 1'b0);
      for (int p = 0; p < 3; p++) if (done_m[1][p]) new_req(1, p, 0, 1'b0);
      if (t == 13) for (int p = 0; p < 3; p++) rq[1][p].valid = 1'b0;
      drive_bridge(1, 1'b1);
      #2;
      if (t % 2 == 1 && t <= 11) begin
        nvec++;
        if (b_oreq.valid !== 1'b1 || b_oreq.addr[31:28] !== 4'(((t - 1) / 2) % 3)) begin
          nerr++;
          $display("FAIL three_ports order t=%0d got=%h want port%0d", t, b_oreq,
                   ((t - 1) / 2) % 3);
        end
      end
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL three_ports oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k),
                   exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL three_ports iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      resetn = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < np(k); p++) begin
          if (done_m[k][p]) begin
            rq[k][p].valid = 1'b0;
          end else if (!rq[k][p].valid) begin
            if ($urandom_range(0, 2) == 0) new_req(k, p, $urandom_range(0, 3), 1'($urandom));
          end else if (own_m[k] != p && $urandom_range(0, 15) == 0) begin
            rq[k][p].valid = 1'b0;
          end
        end
        jitter(k);
        drive_bridge(k, ($urandom_range(0, 2) != 0));
      end
      #2;
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (got_oreq(k) !== exp_oreq(k)) begin
          nerr++;
          $display("FAIL random oreq dut%0d t=%0d got=%h want=%h", k, t, got_oreq(k),
                   exp_oreq(k));
        end
        for (int p = 0; p < np(k); p++) begin
          nvec++;
          if (got_rsp(k, p) !== exp_rsp(k, p)) begin
            nerr++;
            $display("FAIL random iresps dut%0d p%0d t=%0d got=%h want=%h", k, p, t,
                     got_rsp(k, p), exp_rsp(k, p));
          end
        end
      end
      advance();
    end
    resetn = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 3; p++) begin
        rq[k][p]     = '0;
        done_m[k][p] = 1'b0;
      end
      rs[k]     = '0;
      own_m[k]  = -1;
      prio_m[k] = 0;
      beat_m[k] = 0;
    end
    test_reset();
    test_single_requester();
    test_contention();
    test_stall();
    test_single_beat();
    test_reset_mid_burst();
    test_three_ports();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
